fp_addsub_mc: RTL and testbench

//  Multicycle IEEE-754-style floating-point add/subtract unit with start/done handshake.

---
 rtl/fp_addsub_mc.sv | 201 ++++++++++++++++++++
 tb/tb_fp_addsub_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_mc.sv
// fp_addsub_mc: multicycle floating-point add/subtract (IDLE->ALIGN->ADD->NORM->ROUND) with start/done handshake.
// Define FPU_FLAGS_EN to compute {invalid, overflow, underflow, inexact}; otherwise flags are tied to zero.
module fp_addsub_mc #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 op,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [EXP_W+MAN_W:0] result,
   output logic [3:0]           flags
);
   localparam int unsigned W  = 1 + EXP_W + MAN_W;
   localparam int unsigned MW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
   localparam int unsigned EW = EXP_W + 1;   // headroom for carry-out and rounding carry
   localparam logic [EXP_W-1:0] EMAX       = '1;
   localparam logic [EXP_W-1:0] D_COLLAPSE = EXP_W'(MAN_W + 3);
   localparam logic [W-1:0]     QNAN       = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;
   state_t state, state_nx;

   logic                 op_q, sa_q, sb_q;
   logic [EXP_W-1:0]     ea_q, eb_q;
   logic [MAN_W-1:0]     fa_q, fb_q;
   logic                 spec_q, sign_q, zsign_q, sub_q;
   logic [W-1:0]         spec_val_q;
   logic [EW-1:0]        exp_q;
   logic [MW-1:0]        mbig_q, msml_q;
   logic [MW:0]          sum_q;
   logic [MW-1:0]        nm_q;
   logic [EW-1:0]        ne_q;
   logic                 zero_q;

   function automatic logic [EW-1:0] lzc(input logic [MW-1:0] v);
      lzc = EW'(MW);
      for (int unsigned i = 0; i < MW; i++)
         if (v[i]) lzc = EW'(MW - 1 - i);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_ALIGN;
         S_ALIGN: state_nx = S_ADD;
         S_ADD:   state_nx = S_NORM;
         S_NORM:  state_nx = S_ROUND;
         S_ROUND: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb busy = (state != S_IDLE);

   logic                 a_nan, b_nan, a_inf, b_inf, sbe, swap, is_nan;
   logic [MAN_W:0]       ma, mb, m_big, m_sml;
   logic [EXP_W-1:0]     e_big, e_sml, d;
   logic [2*MAN_W+5:0]   sh_wide;
   logic [MW-1:0]        aligned;
   logic [W-1:0]         spec_val;

   always_comb begin
      a_nan = (ea_q == EMAX) && (fa_q != '0);
      b_nan = (eb_q == EMAX) && (fb_q != '0);
      a_inf = (ea_q == EMAX) && (fa_q == '0);
      b_inf = (eb_q == EMAX) && (fb_q == '0);
      sbe   = sb_q ^ op_q;
      // subnormal inputs (exp 0) lose their fraction and behave as signed zero
      ma    = (ea_q == '0) ? '0 : {1'b1, fa_q};
      mb    = (eb_q == '0) ? '0 : {1'b1, fb_q};
      swap  = {eb_q, mb} > {ea_q, ma};
      e_big = swap ? eb_q : ea_q;
      e_sml = swap ? ea_q : eb_q;
      m_big = swap ? mb : ma;
      m_sml = swap ? ma : mb;
      d     = e_big - e_sml;
      sh_wide = {m_sml, 2'b00, {(MAN_W+3){1'b0}}} >> d;
      if (d >= D_COLLAPSE) aligned = {{(MW-1){1'b0}}, |m_sml};
      else                 aligned = {sh_wide[2*MAN_W+5 -: MAN_W+3], |sh_wide[MAN_W+2:0]};
      is_nan = a_nan | b_nan | (a_inf & b_inf & (sa_q ^ sbe));
      if (is_nan)     spec_val = QNAN;
      else if (a_inf) spec_val = {sa_q, EMAX, {MAN_W{1'b0}}};
      else            spec_val = {sbe,  EMAX, {MAN_W{1'b0}}};
   end

   logic [EW-1:0] lz, lim, sh, ne;
   logic [MW-1:0] nm;

   always_comb begin
      lz  = lzc(sum_q[MW-1:0]);
      lim = (exp_q == '0) ? '0 : exp_q - EW'(1);
      sh  = (lz < lim) ? lz : lim;
      if (sum_q[MW]) begin
         nm = {sum_q[MW:2], sum_q[1] | sum_q[0]};
         ne = exp_q + EW'(1);
      end else begin
         nm = sum_q[MW-1:0] << sh;
         ne = exp_q - sh;
      end
   end

   logic             g, r, s, rnd_up, tiny, ovf;
   logic [MAN_W+1:0] rm;
   logic [EW-1:0]    re;
   logic [W-1:0]     res;

   always_comb begin
      g      = nm_q[2];
      r      = nm_q[1];
      s      = nm_q[0];
      rnd_up = g & (r | s | nm_q[3]);
      rm     = {1'b0, nm_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
      re     = rm[MAN_W+1] ? ne_q + EW'(1) : ne_q;
      // normalisation stopped at exp 1 without a leading one: below the normal range
      tiny   = ~nm_q[MW-1];
      ovf    = re >= {1'b0, EMAX};
      if (spec_q)      res = spec_val_q;
      else if (zero_q) res = {zsign_q, {(W-1){1'b0}}};
      else if (tiny)   res = {sign_q, {(W-1){1'b0}}};
      else if (ovf)    res = {sign_q, EMAX, {MAN_W{1'b0}}};
      else             res = {sign_q, re[EXP_W-1:0], rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0]};
   end

   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: if (start) begin
            op_q <= op;
            sa_q <= a[W-1];
            sb_q <= b[W-1];
            ea_q <= a[W-2 -: EXP_W];
            eb_q <= b[W-2 -: EXP_W];
            fa_q <= a[MAN_W-1:0];
            fb_q <= b[MAN_W-1:0];
         end
         S_ALIGN: begin
            spec_q     <= a_nan | b_nan | a_inf | b_inf;
            spec_val_q <= spec_val;
            sign_q     <= swap ? sbe : sa_q;
            zsign_q    <= sa_q & sbe;
            sub_q      <= sa_q ^ sbe;
            exp_q      <= {1'b0, e_big};
            mbig_q     <= {m_big, 3'b000};
            msml_q     <= aligned;
         end
         S_ADD: sum_q <= sub_q ? {1'b0, mbig_q} - {1'b0, msml_q}
                               : {1'b0, mbig_q} + {1'b0, msml_q};
         S_NORM: begin
            nm_q   <= nm;
            ne_q   <= ne;
            zero_q <= (sum_q == '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= (state == S_ROUND);
         if (state == S_ROUND) result <= res;
      end
   end

`ifdef FPU_FLAGS_EN
   logic       inv_q;
   logic [3:0] flags_nx;

   always_ff @(posedge clk) begin
      if (state == S_ALIGN) inv_q <= is_nan;
   end

   always_comb begin
      flags_nx = '0;
      if (spec_q)      flags_nx = {inv_q, 3'b000};
      else if (zero_q) flags_nx = '0;
      else if (tiny)   flags_nx = 4'b0011;
      else if (ovf)    flags_nx = 4'b0101;
      else             flags_nx = {3'b000, g | r | s};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 flags <= '0;
      else if (state == S_ROUND) flags <= flags_nx;
   end
`else
   assign flags = '0;
`endif

endmodule

// File: tb/tb_fp_addsub_mc.sv
// Self-checking bench for fp_addsub_mc (EXP_W=8, MAN_W=23): directed table, handshake corner
// sequences, and random operands checked against an exact wide-integer reference model.
`timescale 1ns/1ps
module tb_fp_addsub_mc;
   logic        clk = 1'b0;
   logic        reset, start, op;
   logic [31:0] a, b, result;
   logic        busy, done;
   logic [3:0]  flags;
   int          n_checks = 0;
   int          n_errors = 0;

   fp_addsub_mc #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] r;
      logic [3:0]  f;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [3:0] exp_flags(input logic [3:0] f);
`ifdef FPU_FLAGS_EN
      return f;
`else
      return 4'b0000;
`endif
   endfunction

   // Exact model: operands become signed integers in units of 2^-149, sum exactly, then round.
   function automatic void ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub,
                                   output logic [31:0] rr, output logic [3:0] ff);
      logic               sx, sy, rs, inexact;
      int                 ex, ey, p, sh, e;
      logic [22:0]        fx, fy;
      logic signed [299:0] vx, vy, sm;
      logic [299:0]       mag, rem, half;
      logic [24:0]        q;
      sx = x[31];  ex = int'(x[30:23]);  fx = x[22:0];
      sy = y[31] ^ sub;  ey = int'(y[30:23]);  fy = y[22:0];
      if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) || (ex == 255 && ey == 255 && sx != sy)) begin
         rr = 32'h7FC00000;  ff = 4'b1000;  return;
      end
      if (ex == 255) begin rr = {sx, 8'hFF, 23'd0};  ff = 4'b0000;  return; end
      if (ey == 255) begin rr = {sy, 8'hFF, 23'd0};  ff = 4'b0000;  return; end
      vx = (ex == 0) ? '0 : (300'({1'b1, fx}) << (ex - 1));
      vy = (ey == 0) ? '0 : (300'({1'b1, fy}) << (ey - 1));
      if (sx) vx = -vx;
      if (sy) vy = -vy;
      sm = vx + vy;
      if (sm == 0) begin rr = {sx & sy, 31'd0};  ff = 4'b0000;  return; end
      rs  = (sm < 0);
      mag = rs ? $unsigned(-sm) : $unsigned(sm);
      p = 0;
      for (int i = 299; i >= 0; i--) if (mag[i]) begin p = i; break; end
      e = p - 22;
      if (e < 1) begin rr = {rs, 31'd0};  ff = 4'b0011;  return; end
      sh   = p - 23;
      q    = 25'(mag >> sh);
      rem  = mag & ((300'(1) << sh) - 300'(1));
      half = (sh == 0) ? '0 : (300'(1) << (sh - 1));
      inexact = (rem != 0);
      if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 25'd1;
      if (q[24]) begin q = q >> 1;  e = e + 1; end
      if (e >= 255) begin rr = {rs, 8'hFF, 23'd0};  ff = 4'b0101; end
      else begin rr = {rs, 8'(e), q[22:0]};  ff = {3'b000, inexact}; end
   endfunction

   task automatic run_check(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                            input logic [31:0] er, input logic [3:0] ef, input string tag);
      int         lat;
      logic [4:0] bz;
      @(negedge clk);
      a = ta;  b = tbv;  op = top;  start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;  a = $urandom;  b = $urandom;  op = ~top;
      lat = -1;  bz = '0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 5) bz[k] = busy;
         if (done) begin lat = k; break; end
      end
      check($sformatf("%s_lat", tag), 32'(lat), 32'd4);
      check($sformatf("%s_busy", tag), 32'(bz), 32'h0F);
      check($sformatf("%s_res", tag), result, er);
      check($sformatf("%s_flags", tag), 32'(flags), 32'(ef));
   endtask

   initial begin
      int          lat, ndone;
      logic [31:0] er;
      logic [3:0]  ef;

      reset = 1'b1;  start = 1'b0;  op = 1'b0;  a = '0;  b = '0;
      vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
      vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
      vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
      vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
      vecs[5]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
      vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
      vecs[7]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000};
      vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000};
      vecs[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
      vecs[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
      vecs[11] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
      vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
      vecs[13] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
      vecs[14] = '{32'hBFC00000, 32'h3F000000, 1'b0, 32'hBF800000, 4'b0000};
      vecs[15] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000};
      vecs[16] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
      vecs[17] = '{32'h3F7FFFFF, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000};
      vecs[18] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101};
      vecs[19] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001};

      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_flags", 32'(flags), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i])
         run_check(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, exp_flags(vecs[i].f), $sformatf("vec%0d", i));

      // start re-pulsed while busy must be ignored; start in the done cycle must be accepted
      @(negedge clk);
      a = 32'h3F800000;  b = 32'h40000000;  op = 1'b0;  start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 32'h40800000;  b = 32'h40800000;  op = 1'b1;  start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int k = 2; k < 14; k++) begin
         if (k > 2) @(negedge clk);
         if (done) begin lat = k; break; end
      end
      check("repulse_lat", 32'(lat), 32'd4);
      check("repulse_res", result, 32'h40400000);
      check("repulse_busy", 32'(busy), 32'd0);
      a = 32'hC0000000;  b = 32'h3F000000;  op = 1'b1;  start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         if (done) begin lat = k; break; end
      end
      check("b2b_lat", 32'(lat), 32'd4);
      check("b2b_res", result, 32'hC0200000);
      check("b2b_flags", 32'(flags), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);

      // reset while the operation sits in NORM
      @(negedge clk);
      a = 32'h3F800000;  b = 32'h40000000;  op = 1'b0;  start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("rst_no_done", 32'(ndone), 32'd0);
      check("rst_result_held", result, 32'd0);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra, rb;
         logic        rop;
         int          ea, t, mode;
         mode = int'($urandom_range(0, 9));
         ra   = $urandom;
         rb   = $urandom;
         rop  = 1'($urandom_range(0, 1));
         ea   = int'($urandom_range(1, 254));
         if (mode <= 7) ra[30:23] = 8'(ea);
         if (mode <= 1) begin
            rb  = ra ^ 32'($urandom_range(0, 255));
            rb[31] = 1'($urandom_range(0, 1));
            rop = ra[31] ^ rb[31] ^ 1'b1;
         end else if (mode <= 6) begin
            t = ea + int'($urandom_range(0, 60)) - 30;
            if (t < 1) t = 1;
            if (t > 254) t = 254;
            rb[30:23] = 8'(t);
         end else if (mode == 8) begin
            ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 1) == 0) ra[22:0] = '0;
         end
         ref_add(ra, rb, rop, er, ef);
         run_check(ra, rb, rop, er, exp_flags(ef), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
